// File: rtl/ram_burst_ctrl.sv
// Burst controller in front of a 128x4 single-port RAM: accepts read/write burst
// commands and streams beats over independent valid/ready write and read channels.
module ram_burst_ctrl #(
  parameter int ADDR_W = 7,
  parameter int DATA_W = 4,
  parameter int LEN_W  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [LEN_W-1:0]  cmd_len,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              wr_valid,
  output logic              wr_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic              busy,
  output logic              done,
  output logic              ram_en,
  output logic              ram_rw,
  output logic [ADDR_W:0]   ram_addr,
  output logic [DATA_W-1:0] ram_din,
  input  logic [DATA_W-1:0] ram_dout
);

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    RD_ISSUE,
    RD_CAPT,
    RD_HOLD,
    DONE
  } state_e;

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   cur_addr_q, cur_addr_d;
  logic [LEN_W-1:0]    beats_left_q, beats_left_d;
  logic [DATA_W-1:0]   rd_data_q, rd_data_d;

  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      cur_addr_q   <= '0;
      beats_left_q <= '0;
      rd_data_q    <= '0;
    end else begin
      state_q      <= state_d;
      cur_addr_q   <= cur_addr_d;
      beats_left_q <= beats_left_d;
      rd_data_q    <= rd_data_d;
    end
  end

  // NOTE: every output gets a default first, so no path through the case infers a latch.
  always_comb begin
    state_d      = state_q;
    cur_addr_d   = cur_addr_q;
    beats_left_d = beats_left_q;
    rd_data_d    = rd_data_q;
    cmd_ready    = 1'b0;
    busy         = 1'b1;
    done         = 1'b0;
    wr_ready     = 1'b0;
    rd_valid     = 1'b0;
    ram_en       = 1'b0;
    ram_rw       = 1'b0;

    unique case (state_q)
      IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
        if (cmd_valid) begin
          cur_addr_d   = cmd_addr;
          beats_left_d = cmd_len;
          state_d      = cmd_write ? WRITE : RD_ISSUE;
        end
      end
      WRITE: begin
        wr_ready = 1'b1;
        ram_en   = wr_valid;
        ram_rw   = 1'b1;
        if (wr_valid) begin
          if (beats_left_q == '0) begin
            state_d = DONE;
          end else begin
            cur_addr_d   = cur_addr_q + ADDR_W'(1);
            beats_left_d = beats_left_q - LEN_W'(1);
          end
        end
      end
      RD_ISSUE: begin
        ram_en  = 1'b1;
        state_d = RD_CAPT;
      end
      RD_CAPT: begin
        // RAM data_out became valid at the RD_ISSUE edge; capture it for the read channel.
        rd_data_d = ram_dout;
        state_d   = RD_HOLD;
      end
      RD_HOLD: begin
        rd_valid = 1'b1;
        if (rd_ready) begin
          if (beats_left_q == '0) begin
            state_d = DONE;
          end else begin
            cur_addr_d   = cur_addr_q + ADDR_W'(1);
            beats_left_d = beats_left_q - LEN_W'(1);
            state_d      = RD_ISSUE;
          end
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign ram_addr = {1'b0, cur_addr_q};
  assign ram_din  = wr_data;
  assign rd_data  = rd_data_q;

endmodule
